ifetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle datapath.
- Takes the datapath's pc and fetches the word from a variable-latency instruction memory using a req/ack handshake.
- Presents instr to the datapath and asserts stall, which gates the pc register, until the word for the current pc is available.
- Holds a one-entry tagged buffer (last fetched word), a timeout watchdog and misalignment detection.

---
 rtl/ifetch_unit.sv | 173 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one-entry tagged buffer in front of a
// variable-latency instruction memory with a req/ack handshake.
// A miss stalls the datapath until the word for the current pc is buffered.
// Misaligned pcs and fetches that time out fill the buffer with NOP and
// raise fetch_err instead of touching memory or hanging the pipeline.
module ifetch_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        fetch_err,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  // Counter is wide enough for TIMEOUT; BUSY exits at TIMEOUT-1 so it never wraps.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic           req_reg,   req_next;
  logic [31:0]    addr_reg,  addr_next;
  logic [CW-1:0]  cnt_reg,   cnt_next;
  logic           drop_reg,  drop_next;
  logic           vld_reg,   vld_next;
  logic           err_reg,   err_next;
  logic [31:0]    tag_reg,   tag_next;
  logic [31:0]    data_reg,  data_next;

  logic hit;
  logic aligned;
  logic keep_result;
  logic timeout_hit;

  // A flush in the same cycle masks the hit so a redirect never sees stale data.
  assign hit         = vld_reg && (tag_reg == pc) && !flush;
  assign aligned     = (pc[1:0] == 2'b00);
  assign keep_result = !drop_reg && !flush;
  assign timeout_hit = (cnt_reg == CNT_LAST);

  assign instr       = hit ? data_reg : NOP;
  assign instr_valid = hit;
  assign stall       = !hit;
  assign fetch_err   = hit && err_reg;
  assign imem_req    = req_reg;
  assign imem_addr   = addr_reg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: launch on an aligned miss, return on ack or timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!hit && !flush && aligned) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (imem_ack || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values: request control and buffer fills.
  always_comb begin
    req_next  = req_reg;
    addr_next = addr_reg;
    cnt_next  = cnt_reg;
    drop_next = drop_reg;
    vld_next  = vld_reg;
    err_next  = err_reg;
    tag_next  = tag_reg;
    data_next = data_reg;
    case (state_reg)
      IDLE: begin
        if (!hit && !flush) begin
          if (aligned) begin
            req_next  = 1'b1;
            addr_next = {pc[31:2], 2'b00};
            cnt_next  = '0;
            drop_next = 1'b0;
          end else begin
            // Misaligned: never reaches memory, buffered as an error entry.
            tag_next  = pc;
            data_next = NOP;
            err_next  = 1'b1;
            vld_next  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (imem_ack) begin
          // Ack wins over a coincident timeout.
          req_next = 1'b0;
          if (keep_result) begin
            tag_next  = addr_reg;
            data_next = imem_rdata;
            err_next  = 1'b0;
            vld_next  = 1'b1;
          end
        end else if (timeout_hit) begin
          req_next = 1'b0;
          if (keep_result) begin
            tag_next  = addr_reg;
            data_next = NOP;
            err_next  = 1'b1;
            vld_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
        // The request keeps running after a flush; its result is discarded.
        if (flush) begin
          drop_next = 1'b1;
        end
      end
      default: begin
        req_next = 1'b0;
      end
    endcase
    if (flush) begin
      vld_next = 1'b0;
    end
  end

  // Datapath registers; reset is asynchronous so a mid-fetch reset drops req at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_reg  <= 1'b0;
      addr_reg <= '0;
      cnt_reg  <= '0;
      drop_reg <= 1'b0;
      vld_reg  <= 1'b0;
      err_reg  <= 1'b0;
      tag_reg  <= '0;
      data_reg <= '0;
    end else begin
      req_reg  <= req_next;
      addr_reg <= addr_next;
      cnt_reg  <= cnt_next;
      drop_reg <= drop_next;
      vld_reg  <= vld_next;
      err_reg  <= err_next;
      tag_reg  <= tag_next;
      data_reg <= data_next;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: table vectors, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_ifetch_unit;

  localparam int unsigned TO     = 4;
  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_err;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack_w;
  logic [31:0] rdata;
  logic        ack_drv;
  logic        tie_ack;

  assign ack_w = tie_ack ? imem_req : ack_drv;

  ifetch_unit #(.TIMEOUT(TO), .NOP(TB_NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .flush      (flush),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .fetch_err  (fetch_err),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (ack_w),
    .imem_rdata (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Memory contents: any address-dependent, nonzero pattern.
  function automatic logic [31:0] memw(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          age;
    bit          drop;
  } pend_t;

  pend_t       pend_q[$];
  logic        m_vld;
  logic        m_err;
  logic [31:0] m_tag;
  logic [31:0] m_data;
  logic [31:0] m_addr;

  function automatic void model_reset();
    pend_q.delete();
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_tag  = '0;
    m_data = '0;
    m_addr = '0;
  endfunction

  function automatic void buf_write(logic [31:0] t, logic [31:0] d, logic e);
    m_tag  = t;
    m_data = d;
    m_err  = e;
    m_vld  = 1'b1;
    $display("txn fill tag=%h data=%h err=%0d t=%0t", t, d, e, $time);
  endfunction

  function automatic void model_step(logic [31:0] p, logic f, logic a, logic [31:0] d);
    logic  h;
    pend_t t;
    h = m_vld && (m_tag == p) && !f;
    if (pend_q.size() == 0) begin
      if (!f && !h) begin
        if (p[1:0] != 2'b00) begin
          buf_write(p, TB_NOP, 1'b1);
        end else begin
          pend_q.push_back('{addr: p, age: 0, drop: 1'b0});
          m_addr = p;
        end
      end
    end else begin
      t = pend_q[0];
      if (a || (t.age == int'(TO) - 1)) begin
        void'(pend_q.pop_front());
        if (!t.drop && !f) buf_write(t.addr, a ? d : TB_NOP, !a);
      end else begin
        pend_q[0].age = t.age + 1;
        if (f) pend_q[0].drop = 1'b1;
      end
    end
    if (f) m_vld = 1'b0;
  endfunction

  // ---------------- cycle helpers ----------------
  logic [31:0] s_pc, s_rdata;
  logic        s_flush, s_ack, s_reset;

  bit          resp_on, resp_rand, req_seen;
  int          resp_delay, cur_delay, wait_n;

  task automatic at_neg();
    logic h;
    @(negedge clk);
    h = m_vld && (m_tag == pc) && !flush;
    chk("model_valid", {31'b0, instr_valid}, {31'b0, h});
    chk("model_stall", {31'b0, stall}, {31'b0, !h});
    chk("model_err",   {31'b0, fetch_err}, {31'b0, h && m_err});
    chk("model_instr", instr, h ? m_data : TB_NOP);
    chk("model_req",   {31'b0, imem_req}, {31'b0, pend_q.size() != 0});
    chk("model_addr",  imem_addr, m_addr);
    s_pc    = pc;
    s_flush = flush;
    s_ack   = ack_w;
    s_rdata = rdata;
    s_reset = reset;
  endtask

  task automatic to_pos();
    @(posedge clk);
    if (!s_reset) model_reset();
    else model_step(s_pc, s_flush, s_ack, s_rdata);
    #1;
    if (resp_on) begin
      if (imem_req) begin
        if (!req_seen) begin
          req_seen  = 1'b1;
          wait_n    = 0;
          cur_delay = resp_rand ? int'($urandom_range(0, 5)) : resp_delay;
        end else begin
          wait_n++;
        end
        ack_drv = (wait_n == cur_delay);
        rdata   = ack_drv ? memw(imem_addr) : $urandom();
      end else begin
        req_seen = 1'b0;
        ack_drv  = resp_rand && ($urandom_range(0, 15) == 0);
        rdata    = $urandom();
      end
    end
  endtask

  task automatic tick();
    at_neg();
    to_pos();
  endtask

  task automatic reset_dut();
    reset     = 1'b0;
    model_reset();
    ack_drv   = 1'b0;
    flush     = 1'b0;
    tie_ack   = 1'b0;
    resp_on   = 1'b0;
    resp_rand = 1'b0;
    req_seen  = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Fetch pc p with the responder acking after 'delay' req cycles; measure latency.
  task automatic fetch_measure(string nm, logic [31:0] p, int delay, int exp_stall,
                               int exp_reqc, logic exp_err, logic [31:0] exp_ins);
    int  stall_n;
    int  req_n;
    bit  got;
    pc         = p;
    resp_delay = delay;
    resp_rand  = 1'b0;
    resp_on    = 1'b1;
    stall_n    = 0;
    req_n      = 0;
    got        = 1'b0;
    for (int i = 0; i < 30; i++) begin
      at_neg();
      if (instr_valid) begin
        got = 1'b1;
        chk({nm, "_instr"}, instr, exp_ins);
        chk({nm, "_err"}, {31'b0, fetch_err}, {31'b0, exp_err});
        chk({nm, "_stall_cycles"}, stall_n, exp_stall);
        chk({nm, "_req_cycles"}, req_n, exp_reqc);
        to_pos();
        break;
      end
      stall_n++;
      if (imem_req) begin
        req_n++;
        chk({nm, "_addr_stable"}, imem_addr, p);
      end
      to_pos();
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no instr_valid expected one within 30 cycles", nm);
    end
    $display("txn %s pc=%h stall=%0d req=%0d", nm, p, stall_n, req_n);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0004;
      2: return 32'h0000_0008;
      3: return 32'h0000_000C;
      4: return 32'h0000_0100;
      5: return 32'h0000_0002;
      6: return 32'h0000_0007;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        ack;
    logic [31:0] rd;
    logic        v;
    logic        s;
    logic        e;
    logic        r;
    logic [31:0] addr;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // misaligned fill, 0-delay fetch, flush masks hit, flush drops in-flight result, timeout
    tbl[0]  = '{32'h6, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0, TB_NOP};
    tbl[1]  = '{32'h6, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0, TB_NOP};
    tbl[2]  = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0, TB_NOP};
    tbl[3]  = '{32'h8, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[4]  = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_2222};
    tbl[5]  = '{32'h8, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0, TB_NOP};
    tbl[6]  = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0, TB_NOP};
    tbl[7]  = '{32'h8, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[8]  = '{32'h8, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[9]  = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0, TB_NOP};
    tbl[10] = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[11] = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[12] = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[13] = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h8, TB_NOP};
    tbl[14] = '{32'h8, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0, TB_NOP};

    // ---- reset state, then release with ack tied to req ----
    reset     = 1'b0;
    model_reset();
    pc        = 32'h0;
    flush     = 1'b0;
    ack_drv   = 1'b0;
    tie_ack   = 1'b0;
    rdata     = 32'h0;
    resp_on   = 1'b0;
    resp_rand = 1'b0;
    req_seen  = 1'b0;
    at_neg();
    chk("rst_instr", instr, TB_NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h1);
    chk("rst_err",   {31'b0, fetch_err}, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    to_pos();
    reset   = 1'b1;
    tie_ack = 1'b1;
    rdata   = 32'h2010_0005;
    at_neg();
    chk("c0_stall", {31'b0, stall}, 32'h1);
    chk("c0_req",   {31'b0, imem_req}, 32'h0);
    to_pos();
    at_neg();
    chk("c1_req",   {31'b0, imem_req}, 32'h1);
    chk("c1_addr",  imem_addr, 32'h0);
    chk("c1_stall", {31'b0, stall}, 32'h1);
    to_pos();
    at_neg();
    chk("c2_valid", {31'b0, instr_valid}, 32'h1);
    chk("c2_instr", instr, 32'h2010_0005);
    chk("c2_stall", {31'b0, stall}, 32'h0);
    to_pos();
    tie_ack = 1'b0;

    // ---- table vectors ----
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      pc      = tbl[i].pc;
      flush   = tbl[i].fl;
      ack_drv = tbl[i].ack;
      rdata   = tbl[i].rd;
      at_neg();
      chk("vec_valid", {31'b0, instr_valid}, {31'b0, tbl[i].v});
      chk("vec_stall", {31'b0, stall}, {31'b0, tbl[i].s});
      chk("vec_err",   {31'b0, fetch_err}, {31'b0, tbl[i].e});
      chk("vec_req",   {31'b0, imem_req}, {31'b0, tbl[i].r});
      chk("vec_instr", instr, tbl[i].ins);
      if (tbl[i].r) chk("vec_addr", imem_addr, tbl[i].addr);
      $display("txn vec %0d pc=%h valid=%0d req=%0d instr=%h", i, pc, instr_valid, imem_req, instr);
      to_pos();
    end
    flush   = 1'b0;
    ack_drv = 1'b0;

    // ---- sequential pcs, ack after 3 wait cycles ----
    reset_dut();
    fetch_measure("seq0", 32'h0, 3, 5, 4, 1'b0, memw(32'h0));
    fetch_measure("seq4", 32'h4, 3, 5, 4, 1'b0, memw(32'h4));
    fetch_measure("seq8", 32'h8, 3, 5, 4, 1'b0, memw(32'h8));

    // ---- timeout, then ack exactly at the threshold cycle ----
    fetch_measure("tmo",  32'h40, 99, 5, 4, 1'b1, TB_NOP);
    fetch_measure("tmo_ack", 32'h44, 3, 5, 4, 1'b0, memw(32'h44));

    // ---- asynchronous reset in the middle of a fetch ----
    reset_dut();
    pc         = 32'h80;
    resp_delay = 99;
    resp_on    = 1'b1;
    tick();
    at_neg();
    chk("mid_req_before", {31'b0, imem_req}, 32'h1);
    to_pos();
    reset   = 1'b0;
    resp_on = 1'b0;
    ack_drv = 1'b0;
    #1;
    chk("async_req",   {31'b0, imem_req}, 32'h0);
    chk("async_stall", {31'b0, stall}, 32'h1);
    model_reset();
    tick();
    reset   = 1'b1;
    ack_drv = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    at_neg();
    chk("stray_valid", {31'b0, instr_valid}, 32'h0);
    to_pos();
    ack_drv = 1'b0;
    at_neg();
    chk("stray_req",   {31'b0, imem_req}, 32'h1);
    chk("stray_valid2", {31'b0, instr_valid}, 32'h0);
    to_pos();
    ack_drv = 1'b1;
    rdata   = 32'h1234_5678;
    tick();
    ack_drv = 1'b0;
    at_neg();
    chk("post_rst_valid", {31'b0, instr_valid}, 32'h1);
    chk("post_rst_instr", instr, 32'h1234_5678);
    to_pos();

    // ---- randomized run against the model ----
    reset_dut();
    resp_on   = 1'b1;
    resp_rand = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (!stall || $urandom_range(0, 19) == 0) pc = pick_pc();
      flush = ($urandom_range(0, 15) == 0);
    end
    resp_on = 1'b0;
    flush   = 1'b0;
    ack_drv = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
